pk_frame_packetizer: RTL and testbench
======================================

Name: pk_frame_packetizer

Overview:
- Sink for the 256-bit peak-result AXI-Stream produced by the range detector, one beat per chirp.
- Serializes each accepted beat into a 5-word, 64-bit AXI-Stream frame for the Ethernet TX path. Word 0 is a header; words 1-4 carry the payload.
- Optionally drops empty results (no peaks on I and Q) and counts emitted and dropped frames.

Parameters:
- S_DATA_WIDTH, 256, input beat width; only 256 is supported.
- M_DATA_WIDTH, 64, output word width; only 64 is supported.
- FILTER_EMPTY, 1, 1 = drop beats with peak_num_i==0 and peak_num_q==0.
- HDR_MAGIC, 32'h504b504b, ASCII 'PKPK' placed in header [63:32].

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  1 = packetize; 0 = sink and drop input beats
- s_pk_axis_tdata  in  256  {peak_num_i[255:224], peak_num_q[223:192], peak_val_i[191:128], peak_val_q[127:64], peak_result_i[63:32], peak_result_q[31:0]}
- s_pk_axis_tvalid  in  1  input valid
- s_pk_axis_tlast  in  1  ignored; every beat is a complete result
- s_pk_axis_tready  out  1  input ready
- m_axis_tdata  out  64  frame word
- m_axis_tkeep  out  8  always 8'hFF while valid
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  high on word 4
- m_axis_tready  in  1  downstream ready
- frame_count  out  32  frames fully emitted (wraps)
- drop_count  out  32  beats dropped, by disable or filter (wraps)
- seq_num  out  16  sequence number of the next frame

Behaviour:
- Reset (async assert, sync release): state IDLE; s_pk_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; m_axis_tkeep=8'hFF; counters=0; seq_num=0; holding register=0.
- State machine: IDLE, HDR, W1, W2, W3, W4.
- s_pk_axis_tready is registered. It is 1 in IDLE, and 1 in W4 when the next-state logic predicts m_axis_tready; it is otherwise 0. It is 0 in the first cycle after reset release.
- Accept event: s_pk_axis_tvalid & s_pk_axis_tready.
  - If enable=0, the beat is dropped: drop_count+1, state unchanged.
  - If FILTER_EMPTY=1 and both peak counts are 0, the beat is dropped: drop_count+1, state unchanged.
  - Otherwise the beat is latched into the holding register and the state goes to HDR.
- Latency: accept at edge N; header valid at edge N+1 (tvalid seen in cycle N+1).
- Frame words:
  - HDR: {HDR_MAGIC, seq_num[15:0], 16'hbeef}
  - W1: {peak_result_i, peak_result_q}
  - W2: peak_val_i
  - W3: peak_val_q
  - W4: {peak_num_i, peak_num_q}, with tlast=1
- Output handshake: standard AXI-Stream. tdata, tlast and tvalid are held stable while tvalid & !tready. A word advances only on tvalid & tready.
- On W4 handshake:
  - frame_count+1 and seq_num+1; seq_num wraps FFFF->0000.
  - If a new beat is accepted in the same cycle, go directly to HDR with no bubble; the new beat uses the incremented seq_num.
  - Otherwise go to IDLE with tvalid=0.
- enable deasserted mid-frame: the current frame completes. The enable check applies only at the next accept.
- Counters wrap at 2^32 with no saturation. A drop and a frame completion in the same cycle both take effect.
- Reset asserted mid-frame: the frame is aborted immediately, no tlast is emitted, and all state returns to reset values.
- Sustained throughput is 1 result per 5 cycles. Upstream backpressure is via tready only; the block has no internal FIFO.

Test Plan:
- Single frame:
  - Stimulus: enable=1, m_tready=1; one beat with peak_num_i=3, peak_num_q=2, peak_val_i=64'h10, peak_val_q=64'h20, peak_result_i=100, peak_result_q=101.
  - Response: 5 consecutive words {504b504b,0000,beef}, {00000064,00000065}, 0x10, 0x20, {00000003,00000002}; tlast only on word 5; frame_count=1; seq_num=1.
- Back-to-back:
  - Stimulus: two beats, tvalid held high, m_tready=1.
  - Response: 10 contiguous valid words with no gap; second header carries seq 0001; s_pk_axis_tready pulses coincide with the W4 handshakes.
- Backpressure:
  - Stimulus: toggle m_tready 1,0,0,1,... during a frame.
  - Response: tdata/tlast stable while stalled; s_pk_axis_tready=0 until the W4 handshake; word order intact.
- Filter and disable:
  - Stimulus: FILTER_EMPTY=1, beat with both peak counts 0; then enable=0 with a valid beat.
  - Response: no output frames; drop_count=2; frame_count unchanged.
- Reset mid-frame:
  - Stimulus: assert aresetn=0 asynchronously during W2; release; send one beat.
  - Response: outputs reset immediately; next frame header has seq 0000.
- Sequence wrap:
  - Stimulus: force seq_num to FFFF; emit two frames.
  - Response: headers carry FFFF then 0000.

Source files
------------

// File: rtl/pk_frame_packetizer.sv
// Packs one 256-bit peak-detector result into a 5-word, 64-bit AXI-Stream frame
// (header + 4 payload words). Optionally drops empty results; counts emitted and dropped frames.
module pk_frame_packetizer #(
   parameter int          S_DATA_WIDTH = 256,
   parameter int          M_DATA_WIDTH = 64,
   parameter bit          FILTER_EMPTY = 1'b1,
   parameter logic [31:0] HDR_MAGIC    = 32'h504b504b
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      enable,
   input  logic [S_DATA_WIDTH-1:0]   s_pk_axis_tdata,
   input  logic                      s_pk_axis_tvalid,
   input  logic                      s_pk_axis_tlast,
   output logic                      s_pk_axis_tready,
   output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic [31:0]               frame_count,
   output logic [31:0]               drop_count,
   output logic [15:0]               seq_num
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR  = 3'd1;
   localparam logic [2:0] W1   = 3'd2;
   localparam logic [2:0] W2   = 3'd3;
   localparam logic [2:0] W3   = 3'd4;
   localparam logic [2:0] W4   = 3'd5;

   logic [2:0]              state, state_n;
   logic [S_DATA_WIDTH-1:0] hold, hold_n;
   logic [M_DATA_WIDTH-1:0] data_n;
   logic [15:0]             seq_n;
   logic                    pending, pending_n;
   logic                    out_fire, accept, empty, take, drop, frame_done, ready_n;

   // Every input beat is a complete result, so tlast carries no information.
   logic unused_tlast;
   assign unused_tlast = s_pk_axis_tlast;

   assign m_axis_tkeep = '1;

   always_comb begin
      out_fire   = m_axis_tvalid & m_axis_tready;
      accept     = s_pk_axis_tvalid & s_pk_axis_tready;
      empty      = (s_pk_axis_tdata[255:224] == 32'd0) && (s_pk_axis_tdata[223:192] == 32'd0);
      take       = accept & enable & ~(FILTER_EMPTY & empty);
      drop       = accept & ~take;
      frame_done = (state == W4) & out_fire;
   end

   // A beat may be taken in W4 while the last word is still stalled; it is parked
   // in the holding register (W4 data is already in the output register) and
   // flagged pending so the next frame starts straight after the W4 handshake.
   always_comb begin
      state_n   = state;
      pending_n = pending;
      case (state)
         IDLE: if (take) state_n = HDR;
         HDR:  if (out_fire) state_n = W1;
         W1:   if (out_fire) state_n = W2;
         W2:   if (out_fire) state_n = W3;
         W3:   if (out_fire) state_n = W4;
         W4: begin
            if (out_fire) begin
               state_n   = (take | pending) ? HDR : IDLE;
               pending_n = 1'b0;
            end else if (take) begin
               pending_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      hold_n  = take ? s_pk_axis_tdata : hold;
      seq_n   = frame_done ? seq_num + 16'd1 : seq_num;
      ready_n = (state_n == IDLE) | ((state_n == W4) & m_axis_tready & ~pending_n);
   end

   always_comb begin
      data_n = '0;
      case (state_n)
         HDR:     data_n = {HDR_MAGIC, seq_n, 16'hbeef};
         W1:      data_n = hold_n[63:0];
         W2:      data_n = hold_n[191:128];
         W3:      data_n = hold_n[127:64];
         W4:      data_n = hold_n[255:192];
         default: data_n = '0;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state            <= IDLE;
         hold             <= '0;
         pending          <= 1'b0;
         s_pk_axis_tready <= 1'b0;
         m_axis_tdata     <= '0;
         m_axis_tvalid    <= 1'b0;
         m_axis_tlast     <= 1'b0;
         frame_count      <= '0;
         drop_count       <= '0;
         seq_num          <= '0;
      end else begin
         state            <= state_n;
         hold             <= hold_n;
         pending          <= pending_n;
         s_pk_axis_tready <= ready_n;
         seq_num          <= seq_n;
         if (state_n != state && state_n != IDLE) m_axis_tdata <= data_n;
         m_axis_tvalid    <= (state_n != IDLE);
         m_axis_tlast     <= (state_n == W4);
         if (frame_done) frame_count <= frame_count + 32'd1;
         if (drop)       drop_count  <= drop_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_pk_frame_packetizer.sv
// Directed bench for pk_frame_packetizer: single frame, back-to-back, backpressure,
// filter/disable drops, sequence wrap and mid-frame reset.
module tb_pk_frame_packetizer;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic         enable = 1'b1;
   logic [255:0] s_tdata = '0;
   logic         s_tvalid = 1'b0;
   logic         s_tlast = 1'b0;
   logic         s_tready;
   logic [63:0]  m_tdata;
   logic [7:0]   m_tkeep;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready = 1'b1;
   logic [31:0]  frame_count, drop_count;
   logic [15:0]  seq_num;

   pk_frame_packetizer dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable),
      .s_pk_axis_tdata(s_tdata), .s_pk_axis_tvalid(s_tvalid), .s_pk_axis_tlast(s_tlast),
      .s_pk_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .frame_count(frame_count), .drop_count(drop_count), .seq_num(seq_num)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Output monitor: handshakes are captured mid-cycle (they complete at the next posedge).
   int          cyc = 0;
   logic [64:0] words[$];
   int          wcyc[$];
   logic        stalled = 1'b0;
   logic [65:0] prev = '0;

   always @(negedge aclk) begin
      cyc++;
      if (stalled) chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, prev);
      stalled = m_tvalid & ~m_tready & aresetn;
      prev    = {m_tvalid, m_tlast, m_tdata};
      if (m_tvalid) chk("tkeep", m_tkeep, 8'hFF);
      if (s_tready && m_tvalid) chk("rdy_only_w4", m_tlast, 1);
      if (m_tvalid && m_tready) begin
         words.push_back({m_tlast, m_tdata});
         wcyc.push_back(cyc);
      end
   end

   function automatic logic [64:0] fword(input logic [255:0] b, input logic [15:0] seq, input int i);
      case (i)
         0:       return {1'b0, 32'h504b504b, seq, 16'hbeef};
         1:       return {1'b0, b[63:0]};
         2:       return {1'b0, b[191:128]};
         3:       return {1'b0, b[127:64]};
         default: return {1'b1, b[255:192]};
      endcase
   endfunction

   task automatic send_beat(input logic [255:0] b);
      bit ok = 0;
      s_tdata  = b;
      s_tvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         if (s_tready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge aclk); #2;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_words(input int n);
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (words.size() >= n) begin ok = 1; break; end
         @(posedge aclk); #1;
      end
      if (!ok) chk("frame_timeout", words.size(), n);
   endtask

   task automatic expect_frame(input string tag, input logic [255:0] b, input logic [15:0] seq);
      wait_words(5);
      for (int i = 0; i < 5; i++) begin
         if (words.size() == 0) return;
         chk($sformatf("%s_w%0d", tag, i), words.pop_front(), fword(b, seq, i));
         void'(wcyc.pop_front());
      end
   endtask

   localparam logic [255:0] B1 = {32'd3, 32'd2, 64'h10, 64'h20, 32'd100, 32'd101};
   localparam logic [255:0] B2 = {32'd1, 32'd0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 32'hAAAA0001, 32'hBBBB0002};
   localparam logic [255:0] B3 = {32'd0, 32'd7, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 32'h12345678, 32'h9ABCDEF0};
   localparam logic [255:0] B4 = {32'd9, 32'd9, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 32'h0000FFFF, 32'hFFFF0000};
   localparam logic [255:0] B5 = {32'd0, 32'd0, 64'h1, 64'h2, 32'd3, 32'd4};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [64:0] exp1 [5];
      exp1[0] = 65'h0_504b504b_0000_beef;
      exp1[1] = 65'h0_00000064_00000065;
      exp1[2] = 65'h0_00000000_00000010;
      exp1[3] = 65'h0_00000000_00000020;
      exp1[4] = 65'h1_00000003_00000002;

      // Reset state, including the first cycle after release
      repeat (3) @(posedge aclk);
      #2 aresetn = 1'b1;
      @(negedge aclk);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tkeep", m_tkeep, 8'hFF);
      chk("rst_counts", {frame_count, drop_count}, 0);
      chk("rst_seq", seq_num, 0);
      @(posedge aclk); #2;

      // Single frame, hand-computed words
      send_beat(B1);
      chk("latency_tvalid", m_tvalid, 1);
      chk("latency_hdr", m_tdata, 64'h504b504b_0000_beef);
      wait_words(5);
      for (int i = 0; i < 5; i++) begin
         if (words.size() == 0) break;
         chk($sformatf("single_w%0d", i), words.pop_front(), exp1[i]);
         void'(wcyc.pop_front());
      end
      chk("single_frame_count", frame_count, 1);
      chk("single_seq", seq_num, 1);

      // Back-to-back: 10 contiguous words
      send_beat(B2);
      send_beat(B3);
      wait_words(10);
      if (wcyc.size() >= 10) chk("b2b_gap", wcyc[9] - wcyc[0], 9);
      expect_frame("b2b_a", B2, 16'd1);
      expect_frame("b2b_b", B3, 16'd2);
      chk("b2b_frame_count", frame_count, 3);

      // Backpressure: m_tready 1,0,0 repeating
      fork
         send_beat(B4);
         begin
            for (int i = 0; i < 24; i++) begin
               m_tready = (i % 3 == 0);
               @(posedge aclk); #2;
            end
            m_tready = 1'b1;
         end
      join
      expect_frame("bp", B4, 16'd3);
      chk("bp_frame_count", frame_count, 4);

      // Empty-result filter, then disable
      send_beat(B5);
      enable = 1'b0;
      send_beat(B1);
      repeat (10) @(posedge aclk);
      #2 enable = 1'b1;
      chk("drop_no_words", words.size(), 0);
      chk("drop_count", drop_count, 2);
      chk("drop_frame_count", frame_count, 4);

      // Sequence wrap
      @(negedge aclk);
      force dut.seq_num = 16'hFFFF;
      @(negedge aclk);
      release dut.seq_num;
      @(negedge aclk);
      chk("wrap_seq_forced", seq_num, 16'hFFFF);
      @(posedge aclk); #2;
      send_beat(B2);
      send_beat(B3);
      expect_frame("wrap_a", B2, 16'hFFFF);
      expect_frame("wrap_b", B3, 16'h0000);
      chk("wrap_frame_count", frame_count, 6);
      chk("wrap_seq_after", seq_num, 1);

      // Reset asserted during W2
      send_beat(B1);
      for (int i = 0; i < 50; i++) begin
         @(posedge aclk);
         if (words.size() >= 2) break;
      end
      #2 aresetn = 1'b0;
      #1;
      chk("mid_rst_tvalid", m_tvalid, 0);
      chk("mid_rst_tlast", m_tlast, 0);
      chk("mid_rst_tdata", m_tdata, 0);
      chk("mid_rst_s_tready", s_tready, 0);
      chk("mid_rst_counts", {frame_count, drop_count, seq_num}, 0);
      words.delete();
      wcyc.delete();
      @(posedge aclk); #2 aresetn = 1'b1;
      send_beat(B4);
      expect_frame("post_rst", B4, 16'd0);
      chk("post_rst_frame_count", frame_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
